// File: rtl/spart_rx_fifo_pkg.sv
// Shared definitions for the SPART receiver: FSM state encodings, default oversample
// ratio and the three-sample majority voter.
package spart_rx_fifo_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spart_rx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO used as the SPART receive buffer.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   push_i, wdata_i  write request and data (dropped when full unless popping)
//   pop_i            remove head (ignored when empty)
//   rdata_o          head entry, combinational from storage; 0 when empty
//   full_o, empty_o  occupancy flags
//   count_o          number of entries held
module spart_rx_fifo_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receiver: oversampled async serial RX with majority-vote bit sampling, optional
// parity, sticky framing/parity/overrun flags and a show-ahead receive FIFO.
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   en              oversample tick (OVERSAMPLE per bit period)
//   RxD             asynchronous serial input, idle high
//   rd_rx           pop FIFO head; clr_err clears the sticky flags
//   RxD_data        FIFO head (valid while RDA); RDA = FIFO not empty
//   fifo_full/count FIFO occupancy
//   frame_err, parity_err, overrun  sticky error flags
module spart_rx_fifo
    import spart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          RxD,
    input  logic                          rd_rx,
    input  logic                          clr_err,
    output logic [DATA_W-1:0]             RxD_data,
    output logic                          RDA,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_W);

    // Samples taken at M-1 and M; the third sample is live at M+1 where the bit is decided.
    localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    logic              rx_meta_q, rx_sync_q;
    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              s0_q, s1_q;
    logic              voted, decide, t_last;
    logic              push, set_fe, set_pe, set_ov;
    logic              frame_err_q, parity_err_q, overrun_q;
    logic              empty;

    assign voted  = majority3(s0_q, s1_q, rx_sync_q);
    assign decide = (t_q == T_DEC);
    assign t_last = (t_q == T_LAST);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        set_fe  = 1'b0;
        set_pe  = 1'b0;
        if (en) begin
            if (state_q != StIdle) t_d = t_last ? '0 : t_q + TW'(1);
            case (state_q)
                StIdle: begin
                    if (!rx_sync_q) begin
                        state_d = StStart;
                        t_d     = '0;
                    end
                end
                StStart: begin
                    if (decide && voted) begin
                        // Low pulse shorter than half a bit: treat as noise.
                        state_d = StIdle;
                        t_d     = '0;
                    end else if (t_last) begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
                StData: begin
                    if (decide) shift_d = {voted, shift_q[DATA_W-1:1]};
                    if (t_last) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = (PARITY_EN != 0) ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
                StParity: begin
                    if (decide && (voted != ((^shift_q) ^ (PARITY_ODD != 0)))) set_pe = 1'b1;
                    if (t_last) state_d = StStop;
                end
                StStop: begin
                    // Leave mid stop bit so a back-to-back start edge is not missed.
                    if (decide) begin
                        if (voted) push = 1'b1;
                        else       set_fe = 1'b1;
                        state_d = StIdle;
                        t_d     = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    t_d     = '0;
                end
            endcase
        end
    end

    assign set_ov = push & fifo_full & ~rd_rx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            state_q      <= StIdle;
            t_q          <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q <= RxD;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            t_q       <= t_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            if (en && t_q == T_LO)  s0_q <= rx_sync_q;
            if (en && t_q == T_MID) s1_q <= rx_sync_q;
            // A set event in the same cycle as clr_err wins.
            frame_err_q  <= set_fe | (frame_err_q  & ~clr_err);
            parity_err_q <= set_pe | (parity_err_q & ~clr_err);
            overrun_q    <= set_ov | (overrun_q    & ~clr_err);
        end
    end

    spart_rx_fifo_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rd_rx),
        .rdata_o (RxD_data),
        .full_o  (fifo_full),
        .empty_o (empty),
        .count_o (count)
    );

    assign RDA        = ~empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
